// File: rtl/alu_op_sequencer_if.sv
// Bundle of request, ALU and result signals between the ALU op sequencer
// and its surroundings. The slave side is the sequencer itself. The master
// side is the environment that issues requests, evaluates the ALU and
// consumes results.
interface alu_op_sequencer_if;
  // upstream request
  logic       in_valid;
  logic       in_ready;
  logic [4:0] in_x;
  logic [4:0] in_y;
  logic [1:0] in_s;
  logic       in_cin;
  // ALU operand drive and result return
  logic [4:0] alu_x;
  logic [4:0] alu_y;
  logic [1:0] alu_s;
  logic       alu_cin;
  logic [4:0] alu_f;
  logic       alu_cout;
  // downstream result
  logic       out_valid;
  logic       out_ready;
  logic [4:0] out_f;
  logic       out_cout;
  logic       out_err;
  logic [7:0] op_count;

  modport master (
    output in_valid, in_x, in_y, in_s, in_cin,
    input  in_ready,
    input  alu_x, alu_y, alu_s, alu_cin,
    output alu_f, alu_cout,
    input  out_valid, out_f, out_cout, out_err, op_count,
    output out_ready
  );

  modport slave (
    input  in_valid, in_x, in_y, in_s, in_cin,
    output in_ready,
    output alu_x, alu_y, alu_s, alu_cin,
    input  alu_f, alu_cout,
    output out_valid, out_f, out_cout, out_err, op_count,
    input  out_ready
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// ALU operation sequencer. It accepts one operation and holds the operands
// stable on the ALU for SETTLE_CYCLES clocks. It then captures the result
// and presents it until downstream takes it. Results taken downstream are
// counted, and the count wraps modulo 256.
module alu_op_sequencer #(
  parameter int SETTLE_CYCLES = 1  // legal range 1..15
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_op_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DONE   = 2'd2
  } state_t;

  // The counter reaches this value on the edge that captures the result.
  localparam logic [3:0] LAST_CNT = 4'(SETTLE_CYCLES - 1);

  state_t     state_reg;
  logic [3:0] cnt_reg;
  logic [4:0] alu_x_reg;
  logic [4:0] alu_y_reg;
  logic [1:0] alu_s_reg;
  logic       alu_cin_reg;
  logic       out_valid_reg;
  logic [4:0] out_f_reg;
  logic       out_cout_reg;
  logic       out_err_reg;
  logic [7:0] op_count_reg;

  // Accept only in IDLE; all other request activity is ignored.
  assign bus.in_ready  = (state_reg == IDLE);
  assign bus.alu_x     = alu_x_reg;
  assign bus.alu_y     = alu_y_reg;
  assign bus.alu_s     = alu_s_reg;
  assign bus.alu_cin   = alu_cin_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.out_f     = out_f_reg;
  assign bus.out_cout  = out_cout_reg;
  assign bus.out_err   = out_err_reg;
  assign bus.op_count  = op_count_reg;

  // Sequencer FSM: accept -> settle -> hold result until handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      cnt_reg       <= 4'd0;
      alu_x_reg     <= 5'd0;
      alu_y_reg     <= 5'd0;
      alu_s_reg     <= 2'd0;
      alu_cin_reg   <= 1'b0;
      out_valid_reg <= 1'b0;
      out_f_reg     <= 5'd0;
      out_cout_reg  <= 1'b0;
      out_err_reg   <= 1'b0;
      op_count_reg  <= 8'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.in_valid) begin
            alu_x_reg   <= bus.in_x;
            alu_y_reg   <= bus.in_y;
            alu_s_reg   <= bus.in_s;
            alu_cin_reg <= bus.in_cin;
            cnt_reg     <= 4'd0;
            state_reg   <= SETTLE;
          end
        end
        SETTLE: begin
          cnt_reg <= cnt_reg + 4'd1;
          if (cnt_reg == LAST_CNT) begin
            out_f_reg     <= bus.alu_f;
            out_cout_reg  <= bus.alu_cout;
            // Add/subtract with cin=0 gives an undefined ALU result. The
            // operation still completes, but the result is flagged.
            out_err_reg   <= (alu_s_reg == 2'b11) && !alu_cin_reg;
            out_valid_reg <= 1'b1;
            state_reg     <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_reg <= 1'b0;
            op_count_reg  <= op_count_reg + 8'd1;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
